// File: rtl/alarm_check.sv
// Alarm match detector and switch-matching mini game that silences the alarm.
// Optional ring timeout enabled by defining ALARM_TIMEOUT_EN.
module alarm_check #(
  parameter int         ROUNDS    = 3,
  parameter logic [9:0] LFSR_SEED = 10'h1A5
`ifdef ALARM_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_SEC = 30
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        spdt4,
  input  logic [15:0] current_time,
  input  logic [15:0] alarm_time,
  input  logic        push_m,
  input  logic [9:0]  spdt_mini_game,
  output logic [9:0]  mini_game_led,
  output logic [2:0]  alarm_state,
  output logic        alarm_active,
  output logic        finish4
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RINGING = 3'd2,
    GAME    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [2:0] ROUNDS_L = 3'(ROUNDS);

  state_t      state;
  state_t      next;
  logic [9:0]  lfsr;
  logic [9:0]  target;
  logic [2:0]  round;
  logic [2:0]  round_inc;
  logic        blink;
  logic        match;
  logic        match_d;
  logic        push_m_d;
  logic        press;
  logic        hit;
  logic        correct;
  logic        last;
  logic        playing;
  logic        enter_ring;
  logic        timeout;

  assign match      = (current_time == alarm_time);
  assign hit        = tick_1hz & match & ~match_d;
  assign press      = push_m & ~push_m_d;
  assign correct    = (spdt_mini_game == target);
  assign round_inc  = round + 3'd1;
  assign last       = (round_inc == ROUNDS_L);
  assign playing    = (state == RINGING) | (state == GAME);
  assign enter_ring = spdt4 & (state != RINGING) & (next == RINGING);

`ifdef ALARM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_SEC - 1);

  logic [7:0] sec_cnt;

  assign timeout = playing & tick_1hz & (sec_cnt == TO_LAST);

  // Seconds spent ringing or playing, restarted on each new ring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_cnt <= 8'd0;
    end else if (!spdt4 || enter_ring) begin
      sec_cnt <= 8'd0;
    end else if (playing && tick_1hz) begin
      sec_cnt <= sec_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    if (!spdt4) begin
      next = IDLE;
    end else begin
      unique case (state)
        IDLE:    next = ARMED;
        ARMED:   if (hit) next = RINGING;
        RINGING: begin
          if (timeout)    next = DONE;
          else if (press) next = GAME;
        end
        GAME: begin
          if (timeout)                      next = DONE;
          else if (press && correct && last) next = DONE;
        end
        DONE:    next = ARMED;
        default: next = IDLE;
      endcase
    end
  end

  always_comb begin
    mini_game_led = 10'd0;
    alarm_state   = state;
    alarm_active  = playing;
    finish4       = (state == DONE);
    unique case (state)
      RINGING: mini_game_led = blink ? 10'h3FF : 10'h000;
      GAME:    mini_game_led = target;
      default: mini_game_led = 10'd0;
    endcase
  end

  // x^10 + x^7 + 1, free running in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_m_d <= 1'b0;
      match_d  <= 1'b0;
    end else begin
      push_m_d <= push_m;
      if (tick_1hz) match_d <= match;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink <= 1'b0;
    end else if (!spdt4 || enter_ring) begin
      blink <= 1'b0;
    end else if (tick_1hz) begin
      blink <= ~blink;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round  <= 3'd0;
      target <= 10'd0;
    end else if (!spdt4) begin
      round  <= 3'd0;
      target <= 10'd0;
    end else if (timeout) begin
      round <= 3'd0;
    end else if (press && state == RINGING) begin
      round  <= 3'd0;
      target <= lfsr;
    end else if (press && state == GAME) begin
      round  <= (correct && !last) ? round_inc : 3'd0;
      target <= lfsr;
    end
  end

endmodule

// File: tb/tb_alarm_check.sv
// Directed bench for alarm_check with a scoreboard of expected output words.
module tb_alarm_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1hz;
  logic        spdt4;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic        push_m;
  logic [9:0]  spdt_mini_game;
  logic [9:0]  mini_game_led;
  logic [2:0]  alarm_state;
  logic        alarm_active;
  logic        finish4;

  int total = 0;
  int bad   = 0;

  string       tag_q[$];
  logic [15:0] val_q[$];
  logic [9:0]  m_lfsr;
  logic [9:0]  tgt;
  logic [15:0] obs;

  alarm_check dut (
    .clk            (clk),
    .reset          (rst),
    .tick_1hz       (tick_1hz),
    .spdt4          (spdt4),
    .current_time   (current_time),
    .alarm_time     (alarm_time),
    .push_m         (push_m),
    .spdt_mini_game (spdt_mini_game),
    .mini_game_led  (mini_game_led),
    .alarm_state    (alarm_state),
    .alarm_active   (alarm_active),
    .finish4        (finish4)
  );

  always #5 clk = ~clk;

  assign obs = {1'b0, finish4, alarm_active, alarm_state, mini_game_led};

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 10'h1A5;
    else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  function automatic logic [15:0] pk(input logic [2:0] st,
                                     input logic [9:0] led,
                                     input logic act,
                                     input logic fin);
    return {1'b0, fin, act, st, led};
  endfunction

  task automatic expect_out(input string t, input logic [15:0] v);
    tag_q.push_back(t);
    val_q.push_back(v);
  endtask

  task automatic pop_check();
    string       t;
    logic [15:0] e;
    total++;
    if (val_q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty obs=%h", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", t, obs, e);
      end
    end
  endtask

  task automatic go(input string t, input logic [15:0] v);
    expect_out(t, v);
    @(posedge clk);
    #1;
    pop_check();
    @(negedge clk);
    tick_1hz = 1'b0;
    push_m   = 1'b0;
  endtask

  task automatic ring();
    current_time = 16'h0104;
    tick_1hz = 1'b1;
    go("pre_match", pk(3'd1, 10'd0, 1'b0, 1'b0));
    current_time = 16'h0105;
    tick_1hz = 1'b1;
    go("ring", pk(3'd2, 10'd0, 1'b1, 1'b0));
  endtask

  task automatic enter_game();
    logic [9:0] t;
    push_m = 1'b1;
    t = m_lfsr;
    go("enter_game", pk(3'd3, t, 1'b1, 1'b0));
    tgt = t;
    go("game_hold", pk(3'd3, tgt, 1'b1, 1'b0));
  endtask

  task automatic press(input logic ok, input logic fin);
    logic [9:0] t;
    spdt_mini_game = ok ? tgt : (tgt ^ 10'h001);
    push_m = 1'b1;
    t = m_lfsr;
    if (fin) begin
      go("solve", pk(3'd4, 10'd0, 1'b0, 1'b1));
      go("back_armed", pk(3'd1, 10'd0, 1'b0, 1'b0));
    end else begin
      go(ok ? "press_ok" : "press_bad", pk(3'd3, t, 1'b1, 1'b0));
      tgt = t;
      go("game_wait", pk(3'd3, tgt, 1'b1, 1'b0));
    end
  endtask

  initial begin
    rst            = 1'b1;
    tick_1hz       = 1'b0;
    spdt4          = 1'b0;
    push_m         = 1'b0;
    current_time   = 16'h0000;
    alarm_time     = 16'h0105;
    spdt_mini_game = 10'd0;
    #3;
    expect_out("reset", pk(3'd0, 10'd0, 1'b0, 1'b0));
    pop_check();
    @(negedge clk);
    rst   = 1'b0;
    spdt4 = 1'b1;
    go("arm", pk(3'd1, 10'd0, 1'b0, 1'b0));

    ring();
    go("ring_hold", pk(3'd2, 10'd0, 1'b1, 1'b0));
    tick_1hz = 1'b1;
    go("blink_on", pk(3'd2, 10'h3FF, 1'b1, 1'b0));
    go("blink_keep", pk(3'd2, 10'h3FF, 1'b1, 1'b0));
    tick_1hz = 1'b1;
    go("blink_off", pk(3'd2, 10'h000, 1'b1, 1'b0));
    tick_1hz = 1'b1;
    go("blink_on2", pk(3'd2, 10'h3FF, 1'b1, 1'b0));
    enter_game();
    spdt_mini_game = tgt ^ 10'h200;
    go("sw_no_press", pk(3'd3, tgt, 1'b1, 1'b0));
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    tick_1hz = 1'b1;
    go("no_rering", pk(3'd1, 10'd0, 1'b0, 1'b0));

    ring();
    enter_game();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);

    ring();
    enter_game();
    spdt4 = 1'b0;
    go("drop_spdt4", pk(3'd0, 10'd0, 1'b0, 1'b0));
    spdt4 = 1'b1;
    go("rearm", pk(3'd1, 10'd0, 1'b0, 1'b0));

`ifdef ALARM_TIMEOUT_EN
    ring();
    for (int k = 1; k < 30; k++) begin
      tick_1hz = 1'b1;
      go("to_ringing", pk(3'd2, (k % 2 == 1) ? 10'h3FF : 10'h000,
                          1'b1, 1'b0));
    end
    tick_1hz = 1'b1;
    go("timeout", pk(3'd4, 10'd0, 1'b0, 1'b1));
    go("to_armed", pk(3'd1, 10'd0, 1'b0, 1'b0));
`endif

    ring();
    enter_game();
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_reset", pk(3'd0, 10'd0, 1'b0, 1'b0));
    pop_check();
    @(negedge clk);
    rst = 1'b0;
    go("post_reset", pk(3'd1, 10'd0, 1'b0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_check.md
Name: alarm_check

Overview:
- Service-4 stage, directly downstream of the time-keeping counter (service 1) and the alarm-set block (service 2).
- Consumes the running BCD time MMSS and the stored BCD alarm time.
- Raises the alarm on match and runs the switch-matching mini game that silences it.
- Drives the 10 mini-game LEDs, the alarm state code and the finish4 flag used to blank the service LEDs.

Parameters:
- ROUNDS, 3: consecutive correct matches needed to silence the alarm (1..7).
- LFSR_SEED, 10'h1A5: non-zero reset value of the pattern LFSR.
- TIMEOUT_SEC, 30: seconds of ringing/game before auto-off (only with ALARM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- tick_1hz  in  1  single-cycle pulse once per second, aligned with current_time update.
- spdt4  in  1  service-4 enable switch (level).
- current_time  in  16  BCD MMSS (4 nibbles).
- alarm_time  in  16  BCD MMSS.
- push_m  in  1  middle button, already debounced (level).
- spdt_mini_game  in  10  mini-game switches.
- mini_game_led  out  10  mini-game LEDs.
- alarm_state  out  3  0 IDLE, 1 ARMED, 2 RINGING, 3 GAME, 4 DONE.
- alarm_active  out  1  high in RINGING and GAME.
- finish4  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset values: all outputs 0; state IDLE; round count 0; LFSR = LFSR_SEED; match and button history regs 0.
- push_m rising edge: registered previous-value compare; press = push_m & ~push_m_d.
- LFSR: 10-bit Fibonacci x^10+x^7+1; advances every clk in every state; never 0.
- match = (current_time == alarm_time), full 16-bit compare. match_d is updated only on tick_1hz.
- hit = tick_1hz & match & ~match_d, so one hit per match episode.
- IDLE -> ARMED when spdt4 = 1.
- ARMED -> RINGING on hit.
- RINGING: mini_game_led = 10'h3FF when blink = 1, else 0.
  - blink toggles on each tick_1hz; blink is cleared on entering RINGING.
  - press -> GAME; target <= LFSR; round <= 0.
- GAME: mini_game_led = target.
  - Correct: press with spdt_mini_game == target. round+1; new target <= LFSR.
    - If round+1 == ROUNDS, go to DONE instead.
  - Wrong: press with mismatch. round <= 0; new target <= LFSR; stay in GAME.
  - Switch changes without a press have no effect.
- DONE: lasts one cycle. finish4 = 1, mini_game_led = 0, then -> ARMED. The ~match_d term blocks re-ringing within the same matching second.
- spdt4 = 0 in any state: IDLE next cycle; round, target and blink cleared; no finish4 pulse.
- hit in GAME or DONE: ignored.
- Simultaneous press and tick_1hz: both take effect. The press decides the transition; blink toggles but is not visible outside RINGING.
- Latency: hit to RINGING = 1 clk. Press edge to state change = 1 clk after the push_m_d sample.
- alarm_active = (state == RINGING) | (state == GAME), registered with the state.

Optional Feature:
- Macro ALARM_TIMEOUT_EN.
- Defined: a 5-bit+ seconds counter clears on entry to RINGING and counts tick_1hz in RINGING and GAME.
  - Reaching TIMEOUT_SEC forces DONE: finish4 pulses, back to ARMED.
  - Timeout has priority over a press in the same cycle.
- Undefined: no counter; the alarm rings indefinitely until solved or spdt4 = 0.

Test Plan:
- Reset mid-GAME: assert reset async -> alarm_state=0, mini_game_led=0, finish4=0 immediately, without waiting for clk.
- spdt4=1, alarm_time=16'h0105, current_time steps 16'h0104 -> 16'h0105 on tick -> alarm_state 1 -> 2 one clk after tick. mini_game_led alternates 3FF/000 on following ticks.
- RINGING, press -> state 3, mini_game_led = LFSR value at press. Set switches = LED and press 3 times -> finish4 one-cycle pulse, alarm_state 4 then 1, alarm_active=0, no re-ring while current_time stays 16'h0105.
- GAME, after 2 correct presses one wrong press (switches = target ^ 10'h001) -> round resets; 3 further correct presses are needed before finish4.
- GAME, drop spdt4 -> alarm_state 0 next clk, no finish4, LEDs 0. Raise spdt4 -> state 1.
- With ALARM_TIMEOUT_EN, TIMEOUT_SEC=30: ring without a press -> finish4 pulses on the 30th tick_1hz after entry, state returns to 1.
